sum_of_squares: RTL and testbench
=================================

# sum_of_squares

Sequential sum-of-squares unit computing X² + Y² for two unsigned operands with a shift-add multiplier, one multiplier bit per cycle. It sits directly upstream of the magnitude/square-root stage: that stage consumes `out_sum` instead of holding a full X×Y lookup table. Valid/ready handshakes are used on both sides.

## Interface
- `WIDTH`, default 8: operand width in bits.
- `clk`, input, 1: clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `clr`, input, 1: synchronous abort. Returns to IDLE and drops `out_valid`.
- `in_valid`, input, 1: operands `in_x`/`in_y` valid.
- `in_ready`, output, 1: block can accept operands. High only in IDLE.
- `in_x`, input, WIDTH: unsigned X operand.
- `in_y`, input, WIDTH: unsigned Y operand.
- `out_valid`, output, 1: `out_sum` holds a completed result.
- `out_ready`, input, 1: downstream accepts the result.
- `out_sum`, output, 2*WIDTH+1: X² + Y², unsigned.
- `busy`, output, 1: high in SQX or SQY.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - SQX: squares X.
  - SQY: squares Y.
  - DONE: `out_valid`=1.
- Acceptance:
  - Happens on an edge in IDLE with `in_valid`=1 and `clr`=0.
  - Latches X into the multiplicand register and into a right-shifting multiplier register.
  - Latches Y into a holding register.
  - Clears the 2*WIDTH+1-bit accumulator. Index i=0. Next state SQX.
- SQX step, one per edge:
  - If multiplier LSB is 1, add the multiplicand to the accumulator.
  - Shift the multiplicand left by 1 and the multiplier right by 1.
  - After WIDTH steps, reload both registers with Y and go to SQY.
- SQY runs the same step. After WIDTH steps, copy the accumulator into `out_sum` and go to DONE.
- Arithmetic:
  - The accumulator is 2*WIDTH+1 bits and never overflows (max 2·(2^WIDTH−1)²).
  - The multiplicand register is 2*WIDTH bits.
- DONE → IDLE on an edge with `out_valid` && `out_ready`.
- `out_sum` updates only when DONE is entered. It holds its value through IDLE and the next computation.
- `clr` has priority over every transition in every state:
  - Next state IDLE, accumulator cleared, `out_sum` unchanged.
  - `clr` together with `in_valid` in IDLE: no acceptance.
- `in_valid` outside IDLE is ignored, since `in_ready`=0. No buffering.
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `busy`=0, `out_sum`=0, all internal registers 0.
- Reset asserted mid-operation aborts immediately and asynchronously. No result is produced.

## Timing
- Let the acceptance edge be E0.
- Compute edges are E1..E(2*WIDTH). The final accumulator update and DONE entry both happen on E(2*WIDTH).
- `out_valid` rises right after E(2*WIDTH). Fixed latency is 2*WIDTH edges (16 for WIDTH=8).
- `busy` is high from after E0 until after E(2*WIDTH).
- While `out_ready` is held low, `out_valid` and `out_sum` stay stable.
- Minimum initiation interval is 2*WIDTH+2 edges: the DONE→IDLE edge, then one edge in IDLE before the next acceptance.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.

## Configuration
- Macro: `SUM_OF_SQUARES_EARLY_EXIT_EN`.
- Defined: a square phase ends after the current step once the shifted multiplier register becomes zero.
  - Each phase always takes at least 1 step.
  - Latency is variable, 2..2*WIDTH edges; `out_valid` rises after the last step.
  - Results are identical to the fixed-latency build.
- Undefined: each phase always runs exactly WIDTH steps, giving fixed 2*WIDTH latency.

## Test plan
- Basic: X=3, Y=4 accepted, `out_ready`=1. Expect `out_sum`=25 and `out_valid` rising 16 edges after acceptance. `in_ready`=1 again one edge after the output handshake.
- Maximum: X=255, Y=255. Expect `out_sum`=130050 (0x1FC02), no overflow.
- Back-pressure: X=10, Y=0, `out_ready`=0 for 20 cycles. `out_valid`=1 and `out_sum`=100 stay stable, `in_ready`=0, and a new `in_valid` is ignored. Release `out_ready` and expect exactly one transfer.
- Abort: `clr` pulsed 5 edges into SQX. Next state IDLE, `out_valid` never asserts, previous `out_sum` retained. A following X=1, Y=1 gives 2.
- Reset mid-operation: drop `rst_n` in SQY. All outputs reach reset values immediately: `in_ready`=1, `out_valid`=0, `busy`=0, `out_sum`=0.
- Early exit (macro defined): X=0, Y=0 gives 0 after 2 edges. X=1, Y=128 gives 16385 after 1+8=9 edges.

Source files
------------

// File: rtl/sum_of_squares.sv
// Sequential X^2 + Y^2 unit: shift-add squaring of X then Y into one accumulator.
// Optional SUM_OF_SQUARES_EARLY_EXIT_EN ends each square phase once the multiplier runs out of set bits.
module sum_of_squares #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_x,
   input  logic [WIDTH-1:0]   in_y,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH:0]   out_sum,
   output logic               busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, SQX, SQY, DONE} state_t;

   state_t              state;
   logic [2*WIDTH-1:0]  mcand;
   logic [WIDTH-1:0]    mplier;
   logic [WIDTH-1:0]    y_hold;
   logic [2*WIDTH:0]    acc;
   logic [CW-1:0]       cnt;

   logic [2*WIDTH:0]    acc_nxt;
   logic [WIDTH-1:0]    mplier_sh;
   logic                last;

   always_comb begin
      acc_nxt   = acc + (mplier[0] ? {1'b0, mcand} : '0);
      mplier_sh = mplier >> 1;
`ifdef SUM_OF_SQUARES_EARLY_EXIT_EN
      // Remaining multiplier bits all zero: further steps cannot change the sum.
      last      = (cnt == CW'(WIDTH - 1)) || (mplier_sh == '0);
`else
      last      = (cnt == CW'(WIDTH - 1));
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         mcand   <= '0;
         mplier  <= '0;
         y_hold  <= '0;
         acc     <= '0;
         cnt     <= '0;
         out_sum <= '0;
      end else if (clr) begin
         state <= IDLE;
         acc   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  mcand  <= {{WIDTH{1'b0}}, in_x};
                  mplier <= in_x;
                  y_hold <= in_y;
                  acc    <= '0;
                  cnt    <= '0;
                  state  <= SQX;
               end
            end
            SQX: begin
               acc    <= acc_nxt;
               mcand  <= mcand << 1;
               mplier <= mplier_sh;
               cnt    <= cnt + CW'(1);
               if (last) begin
                  mcand  <= {{WIDTH{1'b0}}, y_hold};
                  mplier <= y_hold;
                  cnt    <= '0;
                  state  <= SQY;
               end
            end
            SQY: begin
               acc    <= acc_nxt;
               mcand  <= mcand << 1;
               mplier <= mplier_sh;
               cnt    <= cnt + CW'(1);
               if (last) begin
                  out_sum <= acc_nxt;
                  state   <= DONE;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state == SQX) || (state == SQY);

endmodule

// File: tb/tb_sum_of_squares.sv
// Directed + randomized bench for sum_of_squares against an arithmetic x*x+y*y model.
module tb_sum_of_squares;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst_n, clr, in_valid, out_ready;
   logic [W-1:0]   in_x, in_y;
   logic           in_ready, out_valid, busy;
   logic [2*W:0]   out_sum;

   int tests = 0;
   int fails = 0;
   longint last_sum = 0;

   sum_of_squares #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_y(in_y), .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input longint obs, input longint exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int phase_steps(input int v);
`ifdef SUM_OF_SQUARES_EARLY_EXIT_EN
      int n = 1;
      for (int b = 0; b < W; b++) if (((v >> b) & 1) != 0) n = b + 1;
      return n;
`else
      return W;
`endif
   endfunction

   // One transaction: accept, measure latency, hold off out_ready for 'stall' cycles.
   task automatic txn(input int x, input int y, input int stall, input bit poke);
      longint exp_sum = longint'(x) * x + longint'(y) * y;
      int     exp_lat = phase_steps(x) + phase_steps(y);
      int     k = 0;
      @(negedge clk);
      check("in_ready_before_accept", in_ready, 1);
      in_valid = 1'b1; in_x = W'(x); in_y = W'(y); out_ready = 1'b0;
      @(negedge clk);                       // after E0
      in_valid = 1'b0;
      check("busy_after_accept", busy, 1);
      check("in_ready_after_accept", in_ready, 0);
      check("out_sum_held_during_compute", out_sum, last_sum);
      while (!out_valid && k < 4 * W) begin
         @(negedge clk);
         k++;
      end
      check("latency", k, exp_lat);
      check("out_sum", out_sum, exp_sum);
      check("busy_in_done", busy, 0);
      for (int s = 0; s < stall; s++) begin
         if (poke) begin
            in_valid = 1'b1; in_x = W'($urandom); in_y = W'($urandom);
         end
         @(negedge clk);
         check("stall_out_valid", out_valid, 1);
         check("stall_out_sum", out_sum, exp_sum);
         check("stall_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);                       // handshake edge passed
      check("in_ready_after_handshake", in_ready, 1);
      check("out_valid_after_handshake", out_valid, 0);
      @(negedge clk);
      check("single_transfer", out_valid, 0);
      check("out_sum_held_in_idle", out_sum, exp_sum);
      out_ready = 1'b0;
      last_sum = exp_sum;
   endtask

   initial begin
      rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_x = '0; in_y = '0;
      #12;
      check("reset_in_ready", in_ready, 1);
      check("reset_out_valid", out_valid, 0);
      check("reset_busy", busy, 0);
      check("reset_out_sum", out_sum, 0);
      @(negedge clk); rst_n = 1'b1;

      txn(3, 4, 0, 1'b0);
      txn(255, 255, 0, 1'b0);
      txn(10, 0, 20, 1'b1);

      // Abort five steps into SQX; the previous result must survive.
      @(negedge clk);
      in_valid = 1'b1; in_x = 8'd7; in_y = 8'd9;
      @(negedge clk); in_valid = 1'b0;
      repeat (5) @(negedge clk);
      clr = 1'b1;
      @(negedge clk); clr = 1'b0;
      check("clr_in_ready", in_ready, 1);
      check("clr_busy", busy, 0);
      check("clr_out_sum_kept", out_sum, last_sum);
      begin
         bit seen = 1'b0;
         for (int i = 0; i < 3 * W; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
         end
         check("clr_no_out_valid", seen, 0);
      end
      // clr together with in_valid in IDLE must not accept.
      in_valid = 1'b1; clr = 1'b1; in_x = 8'd5; in_y = 8'd5;
      @(negedge clk); in_valid = 1'b0; clr = 1'b0;
      check("clr_blocks_accept", in_ready, 1);
      txn(1, 1, 0, 1'b0);

      // Asynchronous reset during SQY.
      @(negedge clk);
      in_valid = 1'b1; in_x = 8'd200; in_y = 8'd201;
      @(negedge clk); in_valid = 1'b0;
      repeat (W + 2) @(negedge clk);
      check("busy_before_reset", busy, 1);
      rst_n = 1'b0;
      #1;
      check("async_rst_in_ready", in_ready, 1);
      check("async_rst_out_valid", out_valid, 0);
      check("async_rst_busy", busy, 0);
      check("async_rst_out_sum", out_sum, 0);
      @(negedge clk); rst_n = 1'b1;
      last_sum = 0;

      txn(0, 0, 0, 1'b0);
      txn(1, 128, 0, 1'b0);
      for (int r = 0; r < 12; r++)
         txn(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 3)), 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
